// File: rtl/period_meter.sv
// period_meter: measures clk cycles between rising edges of a slow input,
// optionally averaged, with a sticky timeout when the counter saturates.
module period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int AVG_LOG2    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             timeout,
    output logic             busy
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int IDX_W = AVG_LOG2 + 1;
    localparam logic [IDX_W-1:0] N_AVG = IDX_W'(1 << AVG_LOG2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       per_q, per_d;
    logic                   valid_q, valid_d;
    logic                   tout_q, tout_d;
    logic                   busy_q;

    logic                   rise;
    logic [ACC_W-1:0]       sum;
    logic [IDX_W-1:0]       idx_inc;
    logic [ACC_W-1:0]       avg;

    assign rise    = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign sum     = acc_q + ACC_W'(cnt_q);
    assign idx_inc = idx_q + IDX_W'(1);
    assign avg     = sum >> AVG_LOG2;

    // Synchroniser chain plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Measurement state and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            per_q   <= '0;
            valid_q <= 1'b0;
            tout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            per_q   <= per_d;
            valid_q <= valid_d;
            tout_q  <= tout_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Next-state: an edge beats saturation in the same cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        per_d   = per_q;
        valid_d = 1'b0;
        tout_d  = tout_q;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            idx_d   = '0;
            tout_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_W'(1);
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        cnt_d = CNT_W'(1);
                        if (idx_inc == N_AVG) begin
                            per_d   = CNT_W'(avg);
                            valid_d = 1'b1;
                            tout_d  = 1'b0;
                            acc_d   = '0;
                            idx_d   = '0;
                        end else begin
                            acc_d = sum;
                            idx_d = idx_inc;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        tout_d  = 1'b1;
                        cnt_d   = '0;
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign period_out   = per_q;
    assign period_valid = valid_q;
    assign timeout      = tout_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: scoreboard bench over three parameterisations
// (defaults, 4-period averaging, 4-bit counter).
module tb_period_meter;

    typedef struct {
        int per;
        int gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  en;
    logic [2:0]  sig;
    logic        use_div, div_en;
    logic        tq;
    logic [2:0]  dc;
    logic        s0;

    logic [15:0] per0;
    logic [15:0] per1;
    logic [3:0]  per2;
    logic [2:0]  val, tout, busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_n = 0;
    int last0 = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(posedge clk) begin
        if (!div_en) begin
            tq <= 1'b0;
            dc <= '0;
        end else begin
            tq <= ~tq;
            if (!tq) dc <= dc + 3'd1;
        end
    end

    assign s0 = use_div ? dc[2] : sig[0];

    period_meter u0 (
        .clk(clk), .reset(rst), .enable(en[0]), .sig_in(s0),
        .period_out(per0), .period_valid(val[0]),
        .timeout(tout[0]), .busy(busy[0])
    );

    period_meter #(.AVG_LOG2(2)) u1 (
        .clk(clk), .reset(rst), .enable(en[1]), .sig_in(sig[1]),
        .period_out(per1), .period_valid(val[1]),
        .timeout(tout[1]), .busy(busy[1])
    );

    period_meter #(.CNT_W(4)) u2 (
        .clk(clk), .reset(rst), .enable(en[2]), .sig_in(sig[2]),
        .period_out(per2), .period_valid(val[2]),
        .timeout(tout[2]), .busy(busy[2])
    );

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, req, cyc_n);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic period(input int k, input int p);
        sig[k] = 1'b1;
        cyc(p / 2);
        sig[k] = 1'b0;
        cyc(p - p / 2);
    endtask

    task automatic push(input int k, input int p, input int g);
        exp_t e;
        e.per = p;
        e.gap = g;
        if (k == 0) q0.push_back(e);
        else if (k == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && val[0]) begin
            if (q0.size() == 0) begin
                chk("u0_unexpected_strobe", 1, 0);
            end else begin
                e = q0.pop_front();
                chk("u0_period", int'(per0), e.per);
                if (e.gap != 0) chk("u0_gap", cyc_n - last0, e.gap);
            end
            last0 <= cyc_n;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && val[1]) begin
            if (q1.size() == 0) begin
                chk("u1_unexpected_strobe", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("u1_period", int'(per1), e.per);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && val[2]) begin
            chk("u2_timeout_at_strobe", int'(tout[2]), 0);
            if (q2.size() == 0) begin
                chk("u2_unexpected_strobe", 1, 0);
            end else begin
                e = q2.pop_front();
                chk("u2_period", int'(per2), e.per);
            end
        end
    end

    initial begin
        rst = 1'b1;
        en = '0;
        sig = '0;
        use_div = 1'b0;
        div_en = 1'b0;
        cyc(3);
        chk("rst_period", int'(per0), 0);
        chk("rst_valid", int'(val), 0);
        chk("rst_timeout", int'(tout), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        cyc(2);

        // period 8, five edges, four results
        en[0] = 1'b1;
        cyc(2);
        chk("arm_busy", int'(busy[0]), 1);
        period(0, 8);
        for (int i = 0; i < 4; i++) begin
            push(0, 8, 0);
            period(0, 8);
        end
        cyc(6);
        chk("p8_drained", q0.size(), 0);
        chk("p8_timeout", int'(tout[0]), 0);

        // enable dropped mid-measurement
        en[0] = 1'b0;
        cyc(1);
        chk("dis_busy", int'(busy[0]), 0);
        chk("dis_hold", int'(per0), 8);
        cyc(3);
        en[0] = 1'b1;
        cyc(2);
        period(0, 8);
        push(0, 8, 0);
        period(0, 8);
        cyc(6);
        chk("reen_drained", q0.size(), 0);

        // divide-by-8 of a clk/2 toggle: period 16
        en[0] = 1'b0;
        cyc(2);
        use_div = 1'b1;
        en[0] = 1'b1;
        cyc(2);
        push(0, 16, 0);
        for (int i = 0; i < 4; i++) push(0, 16, 16);
        div_en = 1'b1;
        cyc(96);
        en[0] = 1'b0;
        div_en = 1'b0;
        cyc(4);
        chk("div_drained", q0.size(), 0);
        use_div = 1'b0;

        // averaging over 4 periods
        en[1] = 1'b1;
        cyc(2);
        period(1, 8);
        period(1, 8);
        period(1, 10);
        period(1, 10);
        push(1, 9, 0);
        period(1, 8);
        period(1, 8);
        period(1, 8);
        period(1, 9);
        push(1, 8, 0);
        period(1, 8);
        cyc(6);
        chk("avg_drained", q1.size(), 0);
        en[1] = 1'b0;

        // 4-bit counter saturation
        en[2] = 1'b1;
        cyc(2);
        sig[2] = 1'b1;
        cyc(2);
        sig[2] = 1'b0;
        cyc(8);
        chk("sat_pre_timeout", int'(tout[2]), 0);
        cyc(15);
        chk("sat_timeout", int'(tout[2]), 1);
        chk("sat_busy_arm", int'(busy[2]), 1);
        chk("sat_hold", int'(per2), 0);
        period(2, 6);
        push(2, 6, 0);
        period(2, 15);
        push(2, 15, 0);
        period(2, 6);
        chk("sat_timeout_clr", int'(tout[2]), 0);
        chk("sat_drained", q2.size(), 0);
        en[2] = 1'b0;
        cyc(2);

        // reset pulse mid-measurement
        en[0] = 1'b1;
        cyc(2);
        period(0, 8);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_period", int'(per0), 0);
        chk("mid_rst_busy", int'(busy[0]), 0);
        chk("mid_rst_timeout", int'(tout[0]), 0);
        chk("mid_rst_valid", int'(val[0]), 0);
        rst = 1'b0;
        cyc(2);
        period(0, 10);
        push(0, 10, 0);
        period(0, 10);
        cyc(6);
        chk("post_rst_drained", q0.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
